// File: rtl/pc_ctrl_if.sv
// Front-end control bus between the decode latch and the PC controller.
// master drives decode/hazard info, slave returns fetch address and status.
interface pc_ctrl_if;
    logic [15:0] instr;
    logic        branch_taken;
    logic [15:0] jr_addr;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] link_addr;
    logic        flush;
    logic        halted;

    modport master (
        output instr, branch_taken, jr_addr, stall,
        input  pc, link_addr, flush, halted
    );

    modport slave (
        input  instr, branch_taken, jr_addr, stall,
        output pc, link_addr, flush, halted
    );
endinterface

// File: rtl/pc_ctrl.sv
// WISC front-end PC/redirect controller.
// Selects next fetch address, squashes wrong-path decode, freezes on HLT.
module pc_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic      clk,
    input  logic      rst,
    pc_ctrl_if.slave  bus
);
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_JAL = 4'hD;
    localparam logic [3:0] OP_JR  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc_q;
    logic [15:0] pc_nxt;
    logic [15:0] id_pc;
    logic [15:0] id_pc_nxt;

    logic [3:0]  opcode;
    logic        is_b;
    logic        is_jal;
    logic        is_jr;
    logic        is_hlt;
    logic        redirect;
    logic [15:0] id_pc_inc;
    logic [15:0] b_off;
    logic [15:0] jal_off;
    logic [15:0] target;

    assign opcode    = bus.instr[15:12];
    assign is_b      = (opcode == OP_B);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jr     = (opcode == OP_JR);
    assign is_hlt    = (opcode == OP_HLT);
    assign redirect  = (is_b && bus.branch_taken) || is_jal || is_jr;

    assign id_pc_inc = id_pc + 16'd1;
    assign b_off     = {{8{bus.instr[7]}}, bus.instr[7:0]};
    assign jal_off   = {{4{bus.instr[11]}}, bus.instr[11:0]};

    always_comb begin
        target = bus.jr_addr;
        unique case (1'b1)
            is_b:    target = id_pc_inc + b_off;
            is_jal:  target = id_pc_inc + jal_off;
            default: target = bus.jr_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            id_pc <= RESET_PC;
            state <= FLUSH;
        end else begin
            pc_q  <= pc_nxt;
            id_pc <= id_pc_nxt;
            state <= state_nxt;
        end
    end

    // stall freezes everything; deferred actions re-evaluate when it drops
    always_comb begin
        pc_nxt    = pc_q;
        id_pc_nxt = id_pc;
        state_nxt = state;
        if (!bus.stall) begin
            unique case (state)
                FLUSH: begin
                    id_pc_nxt = pc_q;
                    pc_nxt    = pc_q + 16'd1;
                    state_nxt = RUN;
                end
                RUN: begin
                    if (is_hlt) begin
                        state_nxt = HALT;
                    end else if (redirect) begin
                        pc_nxt    = target;
                        state_nxt = FLUSH;
                    end else begin
                        id_pc_nxt = pc_q;
                        pc_nxt    = pc_q + 16'd1;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = FLUSH;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.link_addr = id_pc_inc;
    assign bus.flush     = (state == FLUSH);
    assign bus.halted    = (state == HALT);
endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table, corner
// sequences, then random traffic against a behavioural model.
module tb_pc_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pc_ctrl_if bus ();

    pc_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        bt;
        logic [15:0] jr;
        logic        stall;
        logic [15:0] pc;
        logic [15:0] link;
        logic        flush;
        logic        halted;
    } vec_t;

    vec_t vq[$];

    localparam logic [15:0] ADD = 16'h0000;
    localparam logic [15:0] JR  = 16'hE000;
    localparam logic [15:0] HLT = 16'hF000;

    // behavioural model state
    logic [15:0] m_pc;
    logic [15:0] m_id;
    logic        m_flush;
    logic        m_halt;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] pc,
                           input logic [15:0] link, input logic fl,
                           input logic hl);
        chk({tag, ".pc"}, bus.pc, pc);
        chk({tag, ".link"}, bus.link_addr, link);
        chk({tag, ".flush"}, {15'd0, bus.flush}, {15'd0, fl});
        chk({tag, ".halted"}, {15'd0, bus.halted}, {15'd0, hl});
    endtask

    task automatic drive(input logic r, input logic [15:0] ins,
                         input logic bt, input logic [15:0] jr,
                         input logic st);
        rst              = r;
        bus.instr        = ins;
        bus.branch_taken = bt;
        bus.jr_addr      = jr;
        bus.stall        = st;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sext(input logic [15:0] v,
                                         input int bits);
        int s;
        s = int'(v) & ((1 << bits) - 1);
        if (s >= (1 << (bits - 1))) s = s - (1 << bits);
        return 16'(s);
    endfunction

    task automatic model_step(input logic r, input logic [15:0] ins,
                              input logic bt, input logic [15:0] jr,
                              input logic st);
        logic [3:0] op;
        op = ins[15:12];
        if (r) begin
            m_pc = 16'h0000; m_id = 16'h0000;
            m_flush = 1'b1; m_halt = 1'b0;
        end else if (m_halt || st) begin
        end else if (m_flush) begin
            m_id = m_pc; m_pc = m_pc + 16'd1; m_flush = 1'b0;
        end else if (op == 4'hF) begin
            m_halt = 1'b1;
        end else if (op == 4'hC && bt) begin
            m_pc = m_id + 16'd1 + sext(ins, 8); m_flush = 1'b1;
        end else if (op == 4'hD) begin
            m_pc = m_id + 16'd1 + sext(ins, 12); m_flush = 1'b1;
        end else if (op == 4'hE) begin
            m_pc = jr; m_flush = 1'b1;
        end else begin
            m_id = m_pc; m_pc = m_pc + 16'd1;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //            instr    bt  jr        st  pc        link      fl  hl
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h0001, 16'h0001, 0, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h0002, 16'h0002, 0, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h0003, 16'h0003, 0, 0});
        vq.push_back('{JR,     0, 16'h0010, 0, 16'h0010, 16'h0003, 1, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h0011, 16'h0011, 0, 0});
        vq.push_back('{16'hC0F0,1,16'h0000, 0, 16'h0001, 16'h0011, 1, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h0002, 16'h0002, 0, 0});
        vq.push_back('{JR,     0, 16'h0010, 0, 16'h0010, 16'h0002, 1, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h0011, 16'h0011, 0, 0});
        vq.push_back('{16'hC0F0,0,16'h0000, 0, 16'h0012, 16'h0012, 0, 0});
        vq.push_back('{JR,     0, 16'hFFFE, 0, 16'hFFFE, 16'h0012, 1, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 0, 0});
        vq.push_back('{16'hD003,0,16'h0000, 0, 16'h0002, 16'hFFFF, 1, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h0003, 16'h0003, 0, 0});
        vq.push_back('{JR,     0, 16'h1234, 1, 16'h0003, 16'h0003, 0, 0});
        vq.push_back('{JR,     0, 16'h1234, 1, 16'h0003, 16'h0003, 0, 0});
        vq.push_back('{JR,     0, 16'h1234, 1, 16'h0003, 16'h0003, 0, 0});
        vq.push_back('{JR,     0, 16'h1234, 0, 16'h1234, 16'h0003, 1, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h1235, 16'h1235, 0, 0});
        vq.push_back('{16'hC005,1,16'h0000, 0, 16'h123A, 16'h1235, 1, 0});
        vq.push_back('{JR,     0, 16'h5555, 0, 16'h123B, 16'h123B, 0, 0});
        vq.push_back('{JR,     0, 16'h0020, 0, 16'h0020, 16'h123B, 1, 0});
        vq.push_back('{ADD,    0, 16'h0000, 1, 16'h0020, 16'h123B, 1, 0});
        vq.push_back('{ADD,    0, 16'h0000, 0, 16'h0021, 16'h0021, 0, 0});
        vq.push_back('{HLT,    0, 16'h0000, 0, 16'h0021, 16'h0021, 0, 1});
        vq.push_back('{ADD,    0, 16'h0000, 1, 16'h0021, 16'h0021, 0, 1});
        vq.push_back('{JR,     1, 16'h7777, 0, 16'h0021, 16'h0021, 0, 1});
        vq.push_back('{16'hC0F0,1,16'h0000, 0, 16'h0021, 16'h0021, 0, 1});

        drive(1'b1, 16'hABCD, 1'b1, 16'h9999, 1'b0);
        chk_all("reset", 16'h0000, 16'h0001, 1'b1, 1'b0);

        foreach (vq[i]) begin
            drive(1'b0, vq[i].instr, vq[i].bt, vq[i].jr, vq[i].stall);
            chk_all($sformatf("vec%0d", i), vq[i].pc, vq[i].link,
                    vq[i].flush, vq[i].halted);
        end

        // reset out of HALT
        drive(1'b1, ADD, 1'b0, 16'h0000, 1'b1);
        chk_all("rst_halt", 16'h0000, 16'h0001, 1'b1, 1'b0);
        drive(1'b0, ADD, 1'b0, 16'h0000, 1'b0);
        chk_all("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

        // reset in the middle of a redirect
        drive(1'b0, JR, 1'b0, 16'h0040, 1'b0);
        chk_all("jr40", 16'h0040, 16'h0001, 1'b1, 1'b0);
        drive(1'b1, JR, 1'b0, 16'h0040, 1'b0);
        chk_all("rst_redir", 16'h0000, 16'h0001, 1'b1, 1'b0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic [15:0] ins;
            logic        bt;
            logic [15:0] jr;
            logic        st;
            int          sel;
            r   = (n == 0) || ($urandom_range(0, 199) == 0) ||
                  (m_halt && $urandom_range(0, 5) == 0);
            st  = ($urandom_range(0, 3) == 0);
            bt  = 1'($urandom_range(0, 1));
            jr  = 16'($urandom);
            ins = 16'($urandom);
            sel = $urandom_range(0, 39);
            if (sel < 12)      ins[15:12] = 4'($urandom_range(0, 11));
            else if (sel < 22) ins[15:12] = 4'hC;
            else if (sel < 29) ins[15:12] = 4'hD;
            else if (sel < 38) ins[15:12] = 4'hE;
            else               ins[15:12] = 4'hF;
            drive(r, ins, bt, jr, st);
            model_step(r, ins, bt, jr, st);
            chk_all($sformatf("rnd%0d", n), m_pc, m_id + 16'd1,
                    m_flush, m_halt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
